// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: one RAM access per clock shared by VGA scan-out,
// two pixel writers and a full-frame clear engine.
module vga_fb_arbiter #(
  parameter int unsigned       ADDR_W        = 19,
  parameter int unsigned       DATA_W        = 12,
  parameter int unsigned       FB_DEPTH      = 307200,
  parameter logic [DATA_W-1:0] CLR_COLOR     = '0,
  parameter bit                WR_BLANK_ONLY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_ack,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_ack,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              dbg_clr_state
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  clr_state_t        clr_state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rr;
  logic              rd_pend;

  logic wr_open, elig0, elig1;
  logic gnt_disp, gnt0, gnt1, gnt_clr;

  // Writer handshake: req with addr/data is held until ack; ack is a one-cycle
  // pulse on the edge the write is issued, and a writer whose ack is high is
  // not eligible so a req still held during the ack cycle is not written twice.
  always_comb begin
    wr_open  = !WR_BLANK_ONLY || blank;
    elig0    = wr0_req && !wr0_ack && wr_open;
    elig1    = wr1_req && !wr1_ack && wr_open;
    gnt_disp = disp_req;
    gnt0     = !disp_req && elig0 && (!elig1 || !rr);
    gnt1     = !disp_req && elig1 && (!elig0 || rr);
    gnt_clr  = !disp_req && !elig0 && !elig1 && wr_open && (clr_state == CLEAR);
  end

  assign disp_data     = ram_rdata;
  assign dbg_clr_state = (clr_state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      wr0_ack    <= 1'b0;
      wr1_ack    <= 1'b0;
      rd_pend    <= 1'b0;
      disp_valid <= 1'b0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      rr         <= 1'b0;
      clr_state  <= IDLE;
      clr_cnt    <= '0;
    end else begin
      wr0_ack    <= gnt0;
      wr1_ack    <= gnt1;
      clr_done   <= 1'b0;
      // RAM answers one cycle after the registered enable, hence two stages.
      rd_pend    <= gnt_disp;
      disp_valid <= rd_pend;
      ram_en     <= gnt_disp || gnt0 || gnt1 || gnt_clr;
      ram_we     <= gnt0 || gnt1 || gnt_clr;

      if (gnt_disp) begin
        ram_addr <= disp_addr;
      end else if (gnt0) begin
        ram_addr  <= wr0_addr;
        ram_wdata <= wr0_data;
      end else if (gnt1) begin
        ram_addr  <= wr1_addr;
        ram_wdata <= wr1_data;
      end else if (gnt_clr) begin
        ram_addr  <= clr_cnt;
        ram_wdata <= CLR_COLOR;
      end

      if (gnt0) begin
        rr <= 1'b1;
      end else if (gnt1) begin
        rr <= 1'b0;
      end

      case (clr_state)
        IDLE: begin
          if (clr_start) begin
            clr_state <= CLEAR;
            clr_cnt   <= '0;
            clr_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (gnt_clr) begin
            if (clr_cnt == LAST_ADDR) begin
              clr_state <= IDLE;
              clr_cnt   <= '0;
              clr_busy  <= 1'b0;
              clr_done  <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: clr_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: RAM model, directed scenarios, randomized traffic,
// and a scoreboard fed at stimulus time and drained by an output monitor.
module tb_vga_fb_arbiter;

  localparam int          FBD = 16;
  localparam logic [11:0] CLR = 12'h3C5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        blank;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic [11:0] disp_data;
  logic        disp_valid;
  logic        wr0_req, wr1_req;
  logic [18:0] wr0_addr, wr1_addr;
  logic [11:0] wr0_data, wr1_data;
  logic        wr0_ack, wr1_ack;
  logic        clr_start, clr_busy, clr_done;
  logic        ram_en, ram_we;
  logic [18:0] ram_addr;
  logic [11:0] ram_wdata, ram_rdata;
  logic        dbg_clr_state;

  vga_fb_arbiter #(
    .ADDR_W(19), .DATA_W(12), .FB_DEPTH(FBD), .CLR_COLOR(CLR), .WR_BLANK_ONLY(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .blank(blank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbg_clr_state(dbg_clr_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int exp_clr_addr = 0;

  logic [11:0] mem    [0:1023];
  logic [11:0] ref_fb [0:1023];
  logic [11:0] exp_q[$];
  logic [30:0] exp_wr0_q[$];
  logic [30:0] exp_wr1_q[$];

  logic        s_rq1 = 1'b0, s_rq2 = 1'b0, s_blank1 = 1'b0;
  logic [18:0] s_addr1 = '0;
  bit          stop_rand;

  function automatic logic [11:0] preload(input int a);
    logic [31:0] v;
    v = a * 37 + 11;
    if (a == 5) return 12'hABC;
    return v[11:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous single-port RAM model.
  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = preload(a);
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
        else        ram_rdata <= mem[ram_addr[9:0]];
      end
    end
  end

  // Stimulus sampler: records what the DUT saw at each edge and queues the
  // expected read pixel from the reference frame buffer.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        s_rq1 = 1'b0;
        s_rq2 = 1'b0;
        exp_q.delete();
      end else begin
        s_rq2    = s_rq1;
        s_rq1    = disp_req;
        s_addr1  = disp_addr;
        s_blank1 = blank;
        if (disp_req) exp_q.push_back(ref_fb[disp_addr[9:0]]);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [11:0] e;
    logic [30:0] w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("disp_valid_timing", disp_valid, s_rq2);
        if (disp_valid) begin
          if (exp_q.size() == 0) check("disp_unexpected", disp_valid, 0);
          else begin
            e = exp_q.pop_front();
            check("disp_data", disp_data, e);
          end
        end
        if (s_rq1) begin
          check("disp_issue", {ram_en, ram_we, wr0_ack, wr1_ack, ram_addr},
                {1'b1, 1'b0, 1'b0, 1'b0, s_addr1});
        end else if (wr0_ack || wr1_ack) begin
          check("one_ack", wr0_ack & wr1_ack, 0);
          check("wr_blank", s_blank1, 1);
          if (wr0_ack) begin
            if (exp_wr0_q.size() == 0) check("wr0_unexpected", wr0_ack, 0);
            else begin
              w = exp_wr0_q.pop_front();
              check("wr0_write", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, w});
            end
          end
          if (wr1_ack) begin
            if (exp_wr1_q.size() == 0) check("wr1_unexpected", wr1_ack, 0);
            else begin
              w = exp_wr1_q.pop_front();
              check("wr1_write", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, w});
            end
          end
        end else if (ram_we) begin
          check("clr_write", {ram_en, ram_addr, ram_wdata}, {1'b1, exp_clr_addr[18:0], CLR});
          check("clr_blank", s_blank1, 1);
          exp_clr_addr++;
        end else begin
          check("idle_port", ram_en, 0);
        end
        if (clr_done) begin
          check("clr_done_at_last", exp_clr_addr, FBD);
          check("clr_busy_drop", clr_busy, 0);
          done_count++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input int w, input logic [18:0] a, input logic [11:0] d,
                          output int ack_at);
    bit got;
    ref_fb[a[9:0]] = d;
    if (w == 0) begin
      exp_wr0_q.push_back({a, d});
      wr0_addr = a; wr0_data = d; wr0_req = 1'b1;
    end else begin
      exp_wr1_q.push_back({a, d});
      wr1_addr = a; wr1_data = d; wr1_req = 1'b1;
    end
    got = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      got = (w == 0) ? wr0_ack : wr1_ack;
    end
    ack_at = cyc;
    check((w == 0) ? "wr0_ack_seen" : "wr1_ack_seen", got, 1);
    // Keep req up through the ack cycle, as a synchronous writer would.
    if (got) @(negedge clk);
    if (w == 0) wr0_req = 1'b0;
    else        wr1_req = 1'b0;
    if (!got) begin
      if (w == 0) void'(exp_wr0_q.pop_back());
      else        void'(exp_wr1_q.pop_back());
    end
  endtask

  task automatic run_clear(input bit with_writer, output int edges);
    int  cnt;
    bit  seen_done, seen_ack;
    exp_clr_addr = 0;
    clr_start = 1'b1;
    cnt = 0; seen_done = 0; seen_ack = 0;
    while (cnt < 3000 && !seen_done) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        clr_start = 1'b0;
        check("clr_busy_set", clr_busy, 1);
        check("clr_state_dbg", dbg_clr_state, 1);
      end
      if (with_writer) begin
        if (cnt == 8) begin
          ref_fb[100] = 12'h5A5;
          exp_wr0_q.push_back({19'd100, 12'h5A5});
          wr0_addr = 19'd100; wr0_data = 12'h5A5; wr0_req = 1'b1;
        end else if (wr0_req && seen_ack) begin
          wr0_req = 1'b0;
        end else if (wr0_ack) begin
          seen_ack = 1;
        end
      end
      seen_done = clr_done;
    end
    check("clr_done_seen", seen_done, 1);
    edges = cnt - 1;
    wr0_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0, t1, edges, dc;
    for (int a = 0; a < 1024; a++) ref_fb[a] = preload(a);
    rst_n = 1'b0; blank = 1'b0; disp_req = 1'b0; disp_addr = '0;
    wr0_req = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_req = 1'b0; wr1_addr = '0; wr1_data = '0;
    clr_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 0);
    check("rst_flags", {wr0_ack, wr1_ack, disp_valid, clr_busy, clr_done}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single display read of word 5.
    disp_req = 1'b1; disp_addr = 19'd5;
    @(negedge clk);
    disp_req = 1'b0;
    check("rd_issue", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 19'd5});
    @(negedge clk);
    check("rd_valid", {disp_valid, disp_data}, {1'b1, 12'hABC});
    @(negedge clk);
    check("rd_valid_drop", disp_valid, 0);

    // Both writers at once from reset: writer 0 first.
    blank = 1'b1;
    fork
      do_write(0, 19'd10, 12'h111, t0);
      do_write(1, 19'd20, 12'h222, t1);
    join
    check("rr_order_a", t1 - t0, 1);
    check("mem10", mem[10], 12'h111);
    check("mem20", mem[20], 12'h222);

    // After writer 0 alone, a tie goes to writer 1.
    do_write(0, 19'd30, 12'h333, t0);
    fork
      do_write(0, 19'd40, 12'h444, t0);
      do_write(1, 19'd50, 12'h555, t1);
    join
    check("rr_order_b", t0 - t1, 1);

    // Writers held off outside blanking.
    blank = 1'b0;
    ref_fb[60] = 12'h666;
    exp_wr1_q.push_back({19'd60, 12'h666});
    wr1_addr = 19'd60; wr1_data = 12'h666; wr1_req = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("blank_hold", {ram_we, wr1_ack}, 0);
    end
    blank = 1'b1;
    @(negedge clk);
    check("blank_release", wr1_ack, 1);
    @(negedge clk);
    wr1_req = 1'b0;
    check("blank_single_ack", wr1_ack, 0);

    // Display beats a writer.
    disp_req = 1'b1; disp_addr = 19'd600;
    ref_fb[70] = 12'h777;
    exp_wr0_q.push_back({19'd70, 12'h777});
    wr0_addr = 19'd70; wr0_data = 12'h777; wr0_req = 1'b1;
    @(negedge clk);
    check("prio_wait1", wr0_ack, 0);
    @(negedge clk);
    check("prio_wait2", wr0_ack, 0);
    disp_req = 1'b0;
    @(negedge clk);
    check("prio_grant", wr0_ack, 1);
    @(negedge clk);
    wr0_req = 1'b0;

    // Randomized traffic: reads from the upper region, writes below it.
    stop_rand = 0;
    fork
      begin
        while (!stop_rand) begin
          @(negedge clk);
          disp_req  = ($urandom_range(0, 99) < 50);
          disp_addr = 19'($urandom_range(512, 1023));
        end
        disp_req = 1'b0;
      end
      begin
        while (!stop_rand) begin
          @(negedge clk);
          blank = ($urandom_range(0, 9) < 7);
        end
        blank = 1'b1;
      end
      begin
        fork
          begin
            int t;
            for (int i = 0; i < 40; i++) begin
              repeat ($urandom_range(0, 3)) @(negedge clk);
              do_write(0, 19'(16 + 2 * i), 12'($urandom), t);
            end
          end
          begin
            int t;
            for (int i = 0; i < 40; i++) begin
              repeat ($urandom_range(0, 3)) @(negedge clk);
              do_write(1, 19'(17 + 2 * i), 12'($urandom), t);
            end
          end
        join
        stop_rand = 1;
      end
    join
    repeat (5) @(negedge clk);

    // Frame clear with one writer preemption.
    blank = 1'b1;
    run_clear(1'b1, edges);
    check("clr_edges", edges, 17);
    @(negedge clk);
    check("clr_busy_after", clr_busy, 0);
    repeat (2) @(negedge clk);
    for (int a = 0; a < FBD; a++) check("clr_mem", mem[a], CLR);
    check("clr_wr_mem", mem[100], 12'h5A5);

    // Reset in the middle of a clear.
    exp_clr_addr = 0;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (7) @(negedge clk);
    check("clr_progress", exp_clr_addr, 7);
    dc = done_count;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 0);
    check("rst_mid_flags", {wr0_ack, wr1_ack, disp_valid, clr_busy, clr_done, dbg_clr_state}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_no_done", done_count, dc);
    check("rst_idle", clr_busy, 0);
    run_clear(1'b0, edges);
    check("clr_restart_edges", edges, 16);
    repeat (3) @(negedge clk);

    for (int a = 0; a < FBD; a++) check("final_clr_mem", mem[a], CLR);
    for (int a = FBD; a < 1024; a++) check("final_mem", mem[a], ref_fb[a]);
    check("wr0_q_empty", exp_wr0_q.size(), 0);
    check("wr1_q_empty", exp_wr1_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
